icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines, between the fetch stage and the instruction-memory bus model (`wb_simulator`). A hit returns the instruction one cycle after the request is sampled. A miss refills the whole line from memory, fetching the requested (critical) word first, wrapping within the line. The cache acks as soon as the critical word arrives, then completes the refill in the background. A synchronous flush invalidates all lines.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_store.sv | 60 ++++++
 rtl/icache_dm.sv | 181 ++++++++++++++++++
 tb/tb_icache_dm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg : shared state encoding and address-field width helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int words_per_line);
    return 30 - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_store.sv
// ---------------------------------------------------------------------------
// icache_store : valid/tag/data arrays with one combinational read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W         = off_w(WORDS_PER_LINE),
  localparam int IDX_W         = idx_w(NUM_LINES),
  localparam int TAG_W         = tag_w(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_word_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             word_we_i,
  input  logic [OFF_W-1:0] wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic             tag_we_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             set_valid_i,
  input  logic             flush_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

  // A tag write always invalidates its line so a partial refill never hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      if (tag_we_i)    valid_q[wr_idx_i] <= 1'b0;
      if (set_valid_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i)  tag_q[wr_idx_i]             <= wr_tag_i;
    if (word_we_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm : direct-mapped I-cache, critical-word-first wrapping refill
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(NUM_LINES, WORDS_PER_LINE);

  icache_state_t    state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      inst_q, inst_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             flushed_q, flushed_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] cw_q, cw_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_word;
  logic             addr_lsb_unused;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic [IDX_W-1:0] wr_idx;
  logic             word_we, tag_we, set_valid;
  logic [OFF_W-1:0] fill_word, next_word;
  logic             accept, hit, last_word;

  assign req_tag         = addr[31 -: TAG_W];
  assign req_idx         = addr[OFF_W+2 +: IDX_W];
  assign req_word        = addr[2 +: OFF_W];
  assign addr_lsb_unused = ^addr[1:0];

  assign accept    = (state_q == IDLE) && !flush && req && !ack_q;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign last_word = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
  // Word field arithmetic is OFF_W wide, so it wraps inside the line.
  assign fill_word = cw_q + cnt_q;
  assign next_word = fill_word + OFF_W'(1);
  assign wr_idx    = (state_q == IDLE) ? req_idx : idx_q;

  icache_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (req_idx),
    .rd_word_i   (req_word),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_idx_i    (wr_idx),
    .word_we_i   (word_we),
    .wr_word_i   (fill_word),
    .wr_data_i   (mem_rdata),
    .tag_we_i    (tag_we),
    .wr_tag_i    (req_tag),
    .set_valid_i (set_valid),
    .flush_i     (flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      cw_q       <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      inst_q     <= inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      cw_q       <= cw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit)          state_d = REFILL;
      REFILL:  if (mem_valid && last_word)  state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d      = 1'b0;
    inst_d     = inst_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    cw_d       = cw_q;
    word_we    = 1'b0;
    tag_we     = 1'b0;
    set_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && hit) begin
          ack_d  = 1'b1;
          inst_d = rd_data;
        end else if (accept) begin
          tag_we     = 1'b1;
          tag_d      = req_tag;
          idx_d      = req_idx;
          cw_d       = req_word;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_tag, req_idx, req_word, 2'b00};
        end
      end
      REFILL: begin
        if (flush) flushed_d = 1'b1;
        if (mem_valid) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == '0) begin
            ack_d  = 1'b1;
            inst_d = mem_rdata;
          end
          if (last_word) begin
            // A flush in this very cycle must also keep the line invalid.
            set_valid = !flushed_q && !flush;
            mem_req_d = 1'b0;
            flushed_d = 1'b0;
          end else begin
            mem_addr_d = {tag_q, idx_q, next_word, 2'b00};
          end
        end
      end
      default: ;
    endcase
  end

  assign ack      = ack_q;
  assign inst     = inst_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm : directed scoreboard bench for icache_dm, memory latency 3
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        flush;
  logic [31:0] inst;
  logic        ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_now  = 0;
  int last_raise = 0;
  int lat_cnt  = 0;
  bit ack_prev = 1'b0;

  logic [31:0] exp_q [$];
  logic [31:0] log_q [$];

  icache_dm #(
    .NUM_LINES      (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .flush     (flush),
    .inst      (inst),
    .ack       (ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_now++;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: three negedges after seeing a request, one-cycle valid.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_req) begin
        lat_cnt   = 0;
        mem_valid = 1'b0;
      end else if (mem_valid) begin
        lat_cnt   = 0;
        mem_valid = 1'b0;
      end else begin
        lat_cnt++;
        if (lat_cnt == 3) begin
          mem_valid  = 1'b1;
          mem_rdata  = memf(mem_addr);
          last_raise = cyc_now;
          log_q.push_back(mem_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_not_consecutive", {31'd0, ack && ack_prev}, 32'd0);
      ack_prev = ack;
    end else begin
      ack_prev = 1'b0;
    end
  end

  task automatic fetch(input logic [31:0] a, input bit exp_hit);
    int  cyc;
    bit  saw_mreq;
    bit  got;
    logic [31:0] wa;
    logic [31:0] e;
    wa = {a[31:2], 2'b00};
    @(negedge clk);
    exp_q.push_back(memf(wa));
    addr = a;
    req  = 1'b1;
    cyc = 0; saw_mreq = 1'b0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_req) saw_mreq = 1'b1;
      if (ack) got = 1'b1;
    end
    req = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      e = exp_q.pop_front();
      chk("inst", inst, e);
      if (exp_hit) begin
        chk("hit_latency", cyc, 32'd1);
        chk("hit_no_mem_req", {31'd0, saw_mreq}, 32'd0);
      end else begin
        chk("miss_mem_req", {31'd0, saw_mreq}, 32'd1);
        chk("miss_ack_latency", cyc_now, last_raise + 1);
        if (log_q.size() == 0) chk("crit_addr", 32'hFFFF_FFFF, wa);
        else                   chk("crit_addr", log_q[$], wa);
      end
    end
  endtask

  task automatic check_refill(input logic [31:0] a);
    int n;
    logic [31:0] e;
    logic [1:0]  w;
    n = 0;
    while (mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("refill_done", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = a[3:2] + 2'(i);
      e = {a[31:4], w, 2'b00};
      if (log_q.size() == 0) chk("refill_addr", 32'hFFFF_FFFF, e);
      else                   chk("refill_addr", log_q.pop_front(), e);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    // Cold miss, then hits in the filled line.
    fetch(32'h48, 1'b0);
    check_refill(32'h48);
    fetch(32'h40, 1'b1);
    fetch(32'h4C, 1'b1);

    // Conflict on index 4.
    fetch(32'h448, 1'b0);
    check_refill(32'h448);
    fetch(32'h48, 1'b0);

    // Request held while the previous refill is still in flight.
    fetch(32'h50, 1'b0);
    check_refill(32'h48);
    check_refill(32'h50);
    fetch(32'h54, 1'b1);

    // Flush during refill keeps the line invalid.
    fetch(32'h80, 1'b0);
    pulse_flush();
    check_refill(32'h80);
    fetch(32'h80, 1'b0);
    check_refill(32'h80);
    fetch(32'h84, 1'b1);

    // Flush while idle.
    fetch(32'h40, 1'b0);
    check_refill(32'h40);
    fetch(32'h44, 1'b1);
    pulse_flush();
    fetch(32'h40, 1'b0);
    check_refill(32'h40);

    // Reset in the middle of a refill.
    @(negedge clk);
    addr = 32'h90;
    req  = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_mem_req_up", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    fetch(32'h48, 1'b0);
    check_refill(32'h48);
    fetch(32'h90, 1'b0);
    check_refill(32'h90);

    chk("log_drained", log_q.size(), 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
